if_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of decode: owns the PC, issues one
//  32-bit fetch at a time to instruction memory over a valid/ready request port,

---
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time and buffers the word for decode.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_kill_cnt counter outputs.
module if_fetch #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_inst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [31:0]     perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StOut} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic [PC_W-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~PC_W'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = StIdle;
          end else begin
            if_inst_d  = imem_resp_inst;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = StOut;
          end
        end else if (redirect_valid) begin
          // Response still owed by memory; remember to drop it when it lands.
          kill_d = 1'b1;
        end
      end
      StOut: begin
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          state_d    = StIdle;
        end
        if (if_ready) pc_d = pc_q + PC_W'(4);
      end
      default: state_d = StIdle;
    endcase
    // Redirect target overrides any sequential PC advance.
    if (redirect_valid) pc_d = redirect_tgt;
  end

  always_comb begin
    imem_req_valid = (state_q == StIdle) && !redirect_valid && !rst;
    imem_req_addr  = pc_q & ~PC_W'(3);
    if_valid       = if_valid_q;
    if_inst        = if_inst_q;
    if_pc          = if_pc_q;
  end

`ifdef IF_PERF_CNT_EN
  logic [63:0] fetch_cnt_q;
  logic [31:0] kill_cnt_q;
  logic        fetch_evt;
  logic        kill_evt;

  assign fetch_evt = if_valid_q && if_ready;
  assign kill_evt  = ((state_q == StWait) && imem_resp_valid && (kill_q || redirect_valid)) ||
                     ((state_q == StOut) && redirect_valid && !if_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (fetch_evt) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (kill_evt)  kill_cnt_q  <= kill_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios then random traffic against a
// transaction-level model of program order, outstanding fetches and squashes.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
`ifdef IF_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_inst         (if_inst),
    .if_pc           (if_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_kill_cnt   (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total;
  int unsigned n_bad;

  // Reference model: next PC in program order, one outstanding fetch, squash flag.
  logic [63:0]     m_pc;
  logic [63:0]     m_out_addr;
  bit              m_out;
  bit              m_taint;
  bit              m_valid;
  int              m_wait;
  longint unsigned m_fetch;
  int unsigned     m_kill;
  int              lat_lo;
  int              lat_hi;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] + 32'h8000_0013) ^ a[63:32];
  endfunction

  task automatic model_reset();
    m_pc    = 64'h8000_0000;
    m_out   = 0;
    m_taint = 0;
    m_valid = 0;
    m_wait  = 0;
    m_fetch = 0;
    m_kill  = 0;
  endtask

  // Called at a negedge with inputs set; memory response is driven here from the model.
  task automatic step();
    bit hs, acc, deliver, exp_req;
    if (m_out && m_wait == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = mem_word(m_out_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = $urandom;
      if (m_out) m_wait--;
    end
    #1;
    exp_req = !m_out && !m_valid && !redirect_valid;
    check_eq("if_valid", if_valid, m_valid);
    check_eq("req_valid", imem_req_valid, exp_req);
    if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
    if (m_valid) begin
      check_eq("if_pc", if_pc, m_pc);
      check_eq("if_inst", if_inst, mem_word(m_pc));
    end
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_fetch);
    check_eq("perf_kill", {32'h0, perf_kill_cnt}, {32'h0, m_kill});
`endif
    hs      = m_valid && if_ready;
    acc     = exp_req && imem_req_ready;
    deliver = 0;
    if (imem_resp_valid) begin
      deliver = !m_taint && !redirect_valid;
      if (!deliver) m_kill++;
      m_out = 0;
    end else if (m_out && redirect_valid) begin
      m_taint = 1;
    end
    if (m_valid && redirect_valid && !if_ready) m_kill++;
    if (hs) m_fetch++;
    m_valid = deliver || (m_valid && !if_ready && !redirect_valid);
    if (acc) begin
      m_out      = 1;
      m_taint    = 0;
      m_wait     = int'($urandom_range(lat_hi, lat_lo));
      m_out_addr = m_pc;
    end
    if (redirect_valid) m_pc = redirect_pc & ~64'h3;
    else if (hs)        m_pc = m_pc + 64'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_total         = 0;
    n_bad           = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if_ready        = 1'b0;
    lat_lo          = 0;
    lat_hi          = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_if_inst", if_inst, 0);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // First fetch and handshake.
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    #1 check_eq("first_addr", imem_req_addr, 64'h8000_0000);
    step();
    step();
    #1;
    check_eq("first_inst", if_inst, 32'h0000_0013);
    check_eq("first_pc", if_pc, 64'h8000_0000);
    step();
    #1 check_eq("second_addr", imem_req_addr, 64'h8000_0004);

    // Decode stalls for five cycles while holding a word.
    if_ready = 1'b0;
    step();
    step();
    repeat (5) begin
      #1;
      check_eq("stall_pc", if_pc, 64'h8000_0004);
      check_eq("stall_no_req", imem_req_valid, 0);
      step();
    end
    if_ready = 1'b1;
    step();

    // Redirect while the fetch is outstanding; response lands one cycle later.
    lat_lo = 1;
    lat_hi = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    step();
    #1;
    check_eq("redir_addr", imem_req_addr, 64'h8000_0100);
    check_eq("redir_no_valid", if_valid, 0);
`ifdef IF_PERF_CNT_EN
    check_eq("redir_kill_cnt", {32'h0, perf_kill_cnt}, 64'd1);
`endif

    // Redirect coinciding with the decode handshake.
    lat_lo = 0;
    lat_hi = 0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    #1 check_eq("hs_redir_addr", imem_req_addr, 64'h8000_0200);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    step();
    #1 check_eq("wrap_addr", imem_req_addr, 64'h0);

    // Reset while waiting; the response arrives during reset and must be ignored.
    step();
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_inst  = mem_word(m_out_addr);
    #1;
    check_eq("rstmid_if_valid", if_valid, 0);
    check_eq("rstmid_if_inst", if_inst, 0);
    check_eq("rstmid_if_pc", if_pc, 0);
    check_eq("rstmid_req_valid", imem_req_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rstmid2_if_valid", if_valid, 0);
    check_eq("rstmid2_req_valid", imem_req_valid, 0);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    rst             = 1'b0;
    model_reset();
    #1 check_eq("restart_addr", imem_req_addr, 64'h8000_0000);
    step();

    // Random traffic.
    lat_lo = 0;
    lat_hi = 3;
    repeat (3000) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(2, 0) != 0);
      redirect_valid = ($urandom_range(9, 0) == 0);
      redirect_pc    = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
